fp_round_unit: RTL and testbench
================================

# fp_round_unit

Rounding stage for the FPU that receives pre-rounded results from the arithmetic units (divider, multiplier, adder), applies the rounding mode, and produces the final IEEE-754 single-precision result and RISC-V exception flags. It sits between the `to_round_unit` outputs of the FP arithmetic units and FP register-file writeback. Each result is captured with a valid/ready handshake and processed by a small FSM. The block keeps sticky accrued flags for `fcsr.fflags`.

## Interface
- No parameters; widths are fixed by `float_t` (32 bits).
- `clk_i` in, 1: clock; one clock domain.
- `rst_n_i` in, 1: synchronous, active-low reset.
- `clk_en_i` in, 1: when low, all state and registers hold.
- `to_round_unit_i` in, 32 (`float_t`): unrounded result; mantissa already normalized or denormal.
- `grs_i` in, 3: guard, round and sticky bits below the mantissa LSB.
- `valid_i` in, 1: input valid.
- `ready_o` out, 1: unit can accept an input; equals `state == IDLE`.
- `overflow_i`, `underflow_i`, `invalid_op_i`, `zero_divide_i` in, 1 each: flags from the producing unit.
- `rounding_mode_i` in, 3 (`rnd_mode_e`): RNE=000, RTZ=001, RDN=010, RUP=011, RMM=100.
- `result_o` out, 32 (`float_t`): rounded result.
- `valid_o` out, 1: result valid; equals `state == VALID`.
- `ready_i` in, 1: consumer accepts the result.
- `fflags_o` out, 5: flags for this result, ordered {NV, DZ, OF, UF, NX}.
- `fflags_acc_o` out, 5: sticky accrued flags.
- `clear_flags_i` in, 1: clears the accrued flags.
- `fu_state_o` out (`fu_state_e`): FREE in IDLE, otherwise BUSY.

## Operation
- **FSM states:** IDLE → ROUND → NORMALIZE → VALID → IDLE. Every transition is qualified by `clk_en_i`.
- **IDLE:** on `valid_i`, register the input, `grs_i`, all flags and the rounding mode, then go to ROUND. Inputs are ignored in every other state.
- **ROUND:** compute the increment `inc` with the sub-module:
  - RNE: `g & (r | s | lsb)`
  - RTZ: 0
  - RDN: `sign & (g | r | s)`
  - RUP: `~sign & (g | r | s)`
  - RMM: `g`
- **Addition:** add `inc` to the 31-bit integer {exponent, mantissa}. A mantissa carry propagates into the exponent naturally, including denormal→normal. Register the 31-bit sum, then go to NORMALIZE.
- **NORMALIZE**, special cases first, in this priority:
  1. `invalid_op_i`, an input NaN, or an illegal mode (101/110/111) → 0x7FC00000, NV.
  2. `zero_divide_i` → {sign, 0xFF, 0}, DZ.
  3. Input exponent 0xFF with mantissa 0 → infinity passes through, no flags.
  4. Overflow: sum exponent == 0xFF or `overflow_i`. Result by mode:
     - RNE, RMM: ±inf.
     - RTZ: ±0x7F7FFFFF.
     - RDN: +max or −inf.
     - RUP: +inf or −max.
     - Flags OF, NX.
  5. Otherwise result = {sign, sum}. NX = `g|r|s`. UF = `underflow_i & NX`.
- **VALID:** hold `result_o` and `fflags_o` stable until `ready_i`. On the handshake:
  - go to IDLE;
  - `fflags_acc_o <= (clear_flags_i ? 0 : acc) | fflags_o`.
- **`clear_flags_i` outside a handshake:** `acc <= 0`. When clear and a handshake coincide, the new flags survive.
- **Reset:**
  - `state = IDLE`, so `ready_o = 1`.
  - `valid_o = 0`, `result_o = 0`, `fflags_o = 0`, `fflags_acc_o = 0`.
  - `fu_state_o = FREE`.
  - A reset in any state aborts the operation; nothing is committed to the accrued flags.

## Timing
- Input is captured at edge E0 (`valid_i & ready_o & clk_en_i`). E1 → NORMALIZE, E2 → VALID.
- `valid_o` is high in the cycle after E2: latency 3 cycles from the `valid_i` cycle.
- Handshake at edge Eh (`valid_o & ready_i & clk_en_i`); `ready_o` is high after Eh.
- Minimum throughput: one result per 4 cycles.
- With `clk_en_i` low, the outputs hold their values. `ready_i` is ignored while `clk_en_i` is low.
- Outputs are registered or state-decoded, with no combinational path from input to output. `ready_o` depends only on the state.

## Structure
- **Shared package (Modules_pkg):**
  - `rnd_mode_e`
  - `fflags_t` (packed NV, DZ, OF, UF, NX)
  - constants `CANONICAL_NAN = 32'h7FC00000` and `MAX_FINITE = 31'h7F7FFFFF`
  - reuse the existing `float_t` and `fu_state_e`
- **One combinational sub-module `fp_round_increment`:** inputs sign, lsb, grs and mode; outputs `inc` and `inexact`.

## Test plan
1. RNE ties: 0x3F800001 with grs=100 → 0x3F800002, NX. 0x3F800000 with grs=100 → 0x3F800000, NX.
2. Carry into the exponent: 0x3FFFFFFF with grs=110, RNE → 0x40000000, fflags=00001. Denormal 0x007FFFFF with grs=111, RUP → 0x00800000, NX; with `underflow_i` also set, UF.
3. Overflow: 0x7F7FFFFF with grs=100:
   - RNE → 0x7F800000, fflags=00101.
   - RTZ → 0x7F7FFFFF, NX only.
   - Sign 1 under RUP → 0xFF7FFFFF.
4. Specials:
   - `invalid_op_i` → 0x7FC00000, NV.
   - `zero_divide_i` with sign 1 → 0xFF800000, DZ.
   - Mode 111 → 0x7FC00000, NV.
5. Backpressure: hold `ready_i` low for 5 cycles in VALID. `result_o` and `valid_o` stay stable, `ready_o` stays 0, and a `valid_i` pulse in that window is dropped. A reset asserted in VALID gives `valid_o = 0` and `fflags_acc_o = 0` after the next edge.
6. Accrual: NX result, then an OF result with `clear_flags_i` high at its handshake → `fflags_acc_o = 00101`. `clear_flags_i` alone while IDLE → 00000.

Source files
------------

// File: rtl/fp_round_unit_pkg.sv
// Shared FPU types and constants for the rounding stage: float layout,
// rounding modes, exception flag bundle and functional-unit status.
package fp_round_unit_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exponent;
        logic [22:0] mantissa;
    } float_t;

    typedef enum logic {
        FREE = 1'b0,
        BUSY = 1'b1
    } fu_state_e;

    typedef enum logic [2:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100
    } rnd_mode_e;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } fflags_t;

    localparam logic [31:0] CANONICAL_NAN = 32'h7FC0_0000;
    localparam logic [30:0] MAX_FINITE    = 31'h7F7F_FFFF;

endpackage

// File: rtl/fp_round_increment.sv
// Decides whether the truncated magnitude must be bumped by one ULP for the
// selected rounding mode; undefined modes never increment.
module fp_round_increment
    import fp_round_unit_pkg::*;
(
    input  logic       sign,
    input  logic       lsb,
    input  logic [2:0] grs,
    input  rnd_mode_e  mode,
    output logic       inc,
    output logic       inexact
);

    logic g;
    logic r;
    logic s;

    assign {g, r, s} = grs;
    assign inexact   = g | r | s;

    always_comb begin
        inc = 1'b0;
        case (mode)
            RNE:     inc = g & (r | s | lsb);
            RTZ:     inc = 1'b0;
            RDN:     inc = sign & inexact;
            RUP:     inc = ~sign & inexact;
            RMM:     inc = g;
            default: inc = 1'b0;
        endcase
    end

endmodule

// File: rtl/fp_round_unit.sv
// Final rounding stage of the FPU: rounds a pre-normalized single-precision
// result, resolves special cases and keeps the sticky accrued fflags.
module fp_round_unit
    import fp_round_unit_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_n_i,
    input  logic      clk_en_i,
    input  float_t    to_round_unit_i,
    input  logic [2:0] grs_i,
    input  logic      valid_i,
    output logic      ready_o,
    input  logic      overflow_i,
    input  logic      underflow_i,
    input  logic      invalid_op_i,
    input  logic      zero_divide_i,
    input  rnd_mode_e rounding_mode_i,
    output float_t    result_o,
    output logic      valid_o,
    input  logic      ready_i,
    output fflags_t   fflags_o,
    output fflags_t   fflags_acc_o,
    input  logic      clear_flags_i,
    output fu_state_e fu_state_o
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] ROUND     = 2'd1;
    localparam logic [1:0] NORMALIZE = 2'd2;
    localparam logic [1:0] VALID     = 2'd3;

    logic [1:0] state;

    float_t     in_p0;
    logic [2:0] grs_p0;
    rnd_mode_e  mode_p0;
    logic       ovf_p0;
    logic       unf_p0;
    logic       inv_p0;
    logic       dz_p0;

    logic [30:0] sum_p1;
    logic        nx_p1;

    float_t  result_p2;
    fflags_t flags_p2;
    fflags_t acc;

    logic    inc;
    logic    inexact;
    logic    in_nan;
    logic    in_inf;
    logic    illegal_mode;
    logic    handshake;
    float_t  norm_result;
    fflags_t norm_flags;

    function automatic float_t overflow_result(input logic sign, input rnd_mode_e mode);
        case (mode)
            RTZ:     return {sign, MAX_FINITE};
            RDN:     return sign ? {1'b1, 8'hFF, 23'd0} : {1'b0, MAX_FINITE};
            RUP:     return sign ? {1'b1, MAX_FINITE} : {1'b0, 8'hFF, 23'd0};
            default: return {sign, 8'hFF, 23'd0};
        endcase
    endfunction

    fp_round_increment u_increment (
        .sign    (in_p0.sign),
        .lsb     (in_p0.mantissa[0]),
        .grs     (grs_p0),
        .mode    (mode_p0),
        .inc     (inc),
        .inexact (inexact)
    );

    assign in_nan       = (&in_p0.exponent) & (|in_p0.mantissa);
    assign in_inf       = (&in_p0.exponent) & ~(|in_p0.mantissa);
    assign illegal_mode = !(mode_p0 inside {RNE, RTZ, RDN, RUP, RMM});
    assign handshake    = (state == VALID) && ready_i;

    always_comb begin
        norm_result    = {in_p0.sign, sum_p1};
        norm_flags     = '0;
        norm_flags.nx  = nx_p1;
        norm_flags.uf  = unf_p0 & nx_p1;
        if (inv_p0 || in_nan || illegal_mode) begin
            norm_result   = CANONICAL_NAN;
            norm_flags    = '0;
            norm_flags.nv = 1'b1;
        end else if (dz_p0) begin
            norm_result   = {in_p0.sign, 8'hFF, 23'd0};
            norm_flags    = '0;
            norm_flags.dz = 1'b1;
        end else if (in_inf) begin
            norm_result = in_p0;
            norm_flags  = '0;
        end else if ((&sum_p1[30:23]) || ovf_p0) begin
            norm_result   = overflow_result(in_p0.sign, mode_p0);
            norm_flags    = '0;
            norm_flags.of = 1'b1;
            norm_flags.nx = 1'b1;
        end
    end

    // Stage p0: capture in IDLE; stage p1: increment applied to {exp, mant}
    always_ff @(posedge clk_i) begin
        if (clk_en_i) begin
            if (state == IDLE && valid_i) begin
                in_p0   <= to_round_unit_i;
                grs_p0  <= grs_i;
                mode_p0 <= rounding_mode_i;
                ovf_p0  <= overflow_i;
                unf_p0  <= underflow_i;
                inv_p0  <= invalid_op_i;
                dz_p0   <= zero_divide_i;
            end
            if (state == ROUND) begin
                sum_p1 <= {in_p0.exponent, in_p0.mantissa} + 31'(inc);
                nx_p1  <= inexact;
            end
        end
    end

    // Stage p2: special-case resolution registered into the output holding regs
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state     <= IDLE;
            result_p2 <= '0;
            flags_p2  <= '0;
            acc       <= '0;
        end else if (clk_en_i) begin
            case (state)
                IDLE:      if (valid_i) state <= ROUND;
                ROUND:     state <= NORMALIZE;
                NORMALIZE: begin
                    state     <= VALID;
                    result_p2 <= norm_result;
                    flags_p2  <= norm_flags;
                end
                VALID:     if (ready_i) state <= IDLE;
                default:   state <= IDLE;
            endcase
            // A clear coinciding with a handshake must not swallow the new flags.
            if (handshake) begin
                acc <= (clear_flags_i ? fflags_t'('0) : acc) | flags_p2;
            end else if (clear_flags_i) begin
                acc <= '0;
            end
        end
    end

    assign ready_o      = (state == IDLE);
    assign valid_o      = (state == VALID);
    assign result_o     = result_p2;
    assign fflags_o     = flags_p2;
    assign fflags_acc_o = acc;
    assign fu_state_o   = (state == IDLE) ? FREE : BUSY;

endmodule

// File: tb/tb_fp_round_unit.sv
// Scoreboard bench for fp_round_unit: directed vectors push expected results,
// an independent monitor pops and compares on every output handshake.
module tb_fp_round_unit;
    import fp_round_unit_pkg::*;

    logic      clk = 1'b0;
    logic      rst_n;
    logic      clk_en;
    float_t    to_round;
    logic [2:0] grs;
    logic      valid_in;
    logic      ready_out;
    logic      ovf;
    logic      unf;
    logic      inv;
    logic      dz;
    rnd_mode_e mode;
    float_t    result;
    logic      valid_out;
    logic      ready_in;
    fflags_t   fflags;
    fflags_t   fflags_acc;
    logic      clear_flags;
    fu_state_e fu_state;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  flg;
        string       name;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fp_round_unit dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .clk_en_i        (clk_en),
        .to_round_unit_i (to_round),
        .grs_i           (grs),
        .valid_i         (valid_in),
        .ready_o         (ready_out),
        .overflow_i      (ovf),
        .underflow_i     (unf),
        .invalid_op_i    (inv),
        .zero_divide_i   (dz),
        .rounding_mode_i (mode),
        .result_o        (result),
        .valid_o         (valid_out),
        .ready_i         (ready_in),
        .fflags_o        (fflags),
        .fflags_acc_o    (fflags_acc),
        .clear_flags_i   (clear_flags),
        .fu_state_o      (fu_state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out, expected DUT response", name);
    endtask

    // Monitor: compare on every accepted output beat.
    always @(negedge clk) begin
        if (rst_n && clk_en && valid_out && ready_in) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %h, expected no output", result);
            end else begin
                e = q.pop_front();
                check({e.name, "_res"}, result, e.res);
                check({e.name, "_flags"}, {27'd0, fflags}, {27'd0, e.flg});
            end
        end
    end

    // fl = {overflow, underflow, invalid, zero_divide}
    task automatic issue(input string name, input logic [31:0] x, input logic [2:0] g,
                         input logic [2:0] m, input logic [3:0] fl,
                         input logic [31:0] er, input logic [4:0] ef);
        int n = 0;
        while (!ready_out && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!ready_out) begin
            timeout_fail({name, "_ready"});
            return;
        end
        to_round = x;
        grs      = g;
        mode     = rnd_mode_e'(m);
        {ovf, unf, inv, dz} = fl;
        valid_in = 1'b1;
        q.push_back('{er, ef, name});
        @(posedge clk); #1;
        valid_in = 1'b0;
        {ovf, unf, inv, dz} = 4'b0000;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((q.size() != 0 || !ready_out) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (q.size() != 0 || !ready_out) timeout_fail({name, "_drain"});
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!valid_out && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!valid_out) timeout_fail({name, "_valid"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; clk_en = 1'b1; to_round = '0; grs = 3'b000; valid_in = 1'b0;
        {ovf, unf, inv, dz} = 4'b0000; mode = RNE; ready_in = 1'b1; clear_flags = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ready", 32'(ready_out), 32'd1);
        check("reset_valid", 32'(valid_out), 32'd0);
        check("reset_result", result, 32'h0);
        check("reset_fflags", {27'd0, fflags}, 32'd0);
        check("reset_acc", {27'd0, fflags_acc}, 32'd0);
        check("reset_fu_state", 32'(fu_state == FREE), 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Rounding modes and carries
        issue("rne_tie_odd",   32'h3F800001, 3'b100, 3'b000, 4'b0000, 32'h3F800002, 5'b00001);
        issue("rne_tie_even",  32'h3F800000, 3'b100, 3'b000, 4'b0000, 32'h3F800000, 5'b00001);
        issue("carry_exp",     32'h3FFFFFFF, 3'b110, 3'b000, 4'b0000, 32'h40000000, 5'b00001);
        issue("denorm_rup",    32'h007FFFFF, 3'b111, 3'b011, 4'b0000, 32'h00800000, 5'b00001);
        issue("denorm_rup_uf", 32'h007FFFFF, 3'b111, 3'b011, 4'b0100, 32'h00800000, 5'b00011);
        issue("exact_uf",      32'h00800000, 3'b000, 3'b000, 4'b0100, 32'h00800000, 5'b00000);
        issue("rtz_trunc",     32'h3F800000, 3'b011, 3'b001, 4'b0000, 32'h3F800000, 5'b00001);
        issue("rdn_neg",       32'hBF800000, 3'b001, 3'b010, 4'b0000, 32'hBF800001, 5'b00001);
        issue("rmm_tie",       32'h3F800000, 3'b100, 3'b100, 4'b0000, 32'h3F800001, 5'b00001);
        // Overflow
        issue("ovf_rne",       32'h7F7FFFFF, 3'b100, 3'b000, 4'b0000, 32'h7F800000, 5'b00101);
        issue("ovf_rtz",       32'h7F7FFFFF, 3'b100, 3'b001, 4'b0000, 32'h7F7FFFFF, 5'b00001);
        issue("ovf_rup_neg",   32'hFF7FFFFF, 3'b100, 3'b011, 4'b0000, 32'hFF7FFFFF, 5'b00001);
        issue("ovfi_rdn_pos",  32'h7F000000, 3'b000, 3'b010, 4'b1000, 32'h7F7FFFFF, 5'b00101);
        issue("ovfi_rdn_neg",  32'hFF000000, 3'b000, 3'b010, 4'b1000, 32'hFF800000, 5'b00101);
        // Specials
        issue("invalid",       32'h3F800000, 3'b000, 3'b000, 4'b0010, 32'h7FC00000, 5'b10000);
        issue("div_zero_neg",  32'hBF800000, 3'b000, 3'b000, 4'b0001, 32'hFF800000, 5'b01000);
        issue("mode_111",      32'h3F800000, 3'b000, 3'b111, 4'b0000, 32'h7FC00000, 5'b10000);
        issue("in_nan",        32'h7F800001, 3'b000, 3'b000, 4'b0000, 32'h7FC00000, 5'b10000);
        issue("inf_pass",      32'hFF800000, 3'b000, 3'b001, 4'b0000, 32'hFF800000, 5'b00000);
        drain("directed");

        // Backpressure with a dropped input pulse
        ready_in = 1'b0;
        issue("bp", 32'h3F800001, 3'b100, 3'b000, 4'b0000, 32'h3F800002, 5'b00001);
        wait_valid("bp");
        for (int i = 0; i < 5; i++) begin
            check("bp_valid_hold", 32'(valid_out), 32'd1);
            check("bp_result_hold", result, 32'h3F800002);
            check("bp_ready_low", 32'(ready_out), 32'd0);
            check("bp_busy", 32'(fu_state == BUSY), 32'd1);
            if (i == 1) begin
                to_round = 32'h40400000;
                valid_in = 1'b1;
            end else begin
                valid_in = 1'b0;
            end
            @(posedge clk); #1;
        end
        valid_in = 1'b0;
        ready_in = 1'b1;
        drain("bp");
        repeat (6) @(posedge clk);
        #1;
        check("bp_dropped", 32'(valid_out), 32'd0);

        // clk_en low freezes a pending handshake
        ready_in = 1'b0;
        issue("clken", 32'h3F800000, 3'b000, 3'b000, 4'b0000, 32'h3F800000, 5'b00000);
        wait_valid("clken");
        clk_en   = 1'b0;
        ready_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("clken_hold_valid", 32'(valid_out), 32'd1);
        clk_en = 1'b1;
        drain("clken");

        // Reset while holding a result
        ready_in = 1'b0;
        issue("rstv", 32'h3F800001, 3'b100, 3'b000, 4'b0000, 32'h3F800002, 5'b00001);
        wait_valid("rstv");
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rstv_valid", 32'(valid_out), 32'd0);
        check("rstv_acc", {27'd0, fflags_acc}, 32'd0);
        check("rstv_ready", 32'(ready_out), 32'd1);
        rst_n = 1'b1;
        q.delete();
        ready_in = 1'b1;
        @(posedge clk); #1;

        // Accrual and clear
        issue("acc_nx", 32'h3F800001, 3'b100, 3'b000, 4'b0000, 32'h3F800002, 5'b00001);
        drain("acc_nx");
        check("acc_after_nx", {27'd0, fflags_acc}, 32'h01);
        ready_in = 1'b0;
        issue("acc_of", 32'h7F7FFFFF, 3'b100, 3'b000, 4'b0000, 32'h7F800000, 5'b00101);
        wait_valid("acc_of");
        clear_flags = 1'b1;
        ready_in    = 1'b1;
        @(posedge clk); #1;
        clear_flags = 1'b0;
        check("acc_clear_hs", {27'd0, fflags_acc}, 32'h05);
        drain("acc_of");
        clear_flags = 1'b1;
        @(posedge clk); #1;
        clear_flags = 1'b0;
        check("acc_clear_idle", {27'd0, fflags_acc}, 32'h00);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
